// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands the single UART transmitter to one of NREQ
// byte-stream requesters for a whole packet, with a stall watchdog.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1000000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_done,
  output logic              busy,
  output logic              timeout
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                last_q, last_d;
  logic                tx_wr_q, tx_wr_d;
  logic [NREQ-1:0]     req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;

  logic                arb_found;
  logic [PW-1:0]       arb_idx;
  logic                sel_valid;
  logic [7:0]          sel_data;
  logic                stall, accept, done;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  // Descending scan so the lowest offset from ptr+1 wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[wrap_idx(ptr_q, k)]) begin
        arb_found = 1'b1;
        arb_idx   = wrap_idx(ptr_q, k);
      end
    end
  end

  assign sel_valid = req_valid[ptr_q];
  assign sel_data  = req_data[8*int'(ptr_q) +: 8];
  assign stall     = (state_q != IDLE) && (cnt_q == CNT_MAX);
  assign accept    = (state_q == SEND) && !stall && sel_valid;
  // tx_wr_q high marks the first WAIT cycle, where tx_done cannot be ours yet.
  assign done      = (state_q == WAIT) && !stall && tx_done && !tx_wr_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_found) state_d = SEND;
      SEND:    if (stall) state_d = IDLE;
               else if (accept) state_d = WAIT;
      WAIT:    if (stall) state_d = IDLE;
               else if (done) state_d = last_q ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    tx_data_d   = tx_data_q;
    last_d      = last_q;
    tx_wr_d     = 1'b0;
    req_ready_d = '0;
    timeout_d   = 1'b0;
    busy_d      = (state_d != IDLE);
    case (state_q)
      IDLE: if (arb_found) begin
        grant_d          = '0;
        grant_d[arb_idx] = 1'b1;
        ptr_d            = arb_idx;
        cnt_d            = '0;
      end
      SEND: if (stall) begin
        timeout_d = 1'b1;
        grant_d   = '0;
      end else if (accept) begin
        tx_data_d   = sel_data;
        last_d      = req_last[ptr_q];
        tx_wr_d     = 1'b1;
        req_ready_d = grant_q;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      WAIT: if (stall) begin
        timeout_d = 1'b1;
        grant_d   = '0;
      end else if (done) begin
        if (last_q) grant_d = '0;
        else        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      grant_q     <= '0;
      ptr_q       <= PW'(NREQ - 1);
      cnt_q       <= '0;
      tx_data_q   <= '0;
      last_q      <= 1'b0;
      tx_wr_q     <= 1'b0;
      req_ready_q <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      tx_data_q   <= tx_data_d;
      last_q      <= last_d;
      tx_wr_q     <= tx_wr_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign tx_data   = tx_data_q;
  assign tx_wr     = tx_wr_q;
  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single `uart_transceiver` transmitter between `NREQ` byte-stream requesters, such as the motion status reporter, the command echo and debug dump. Each requester owns the transmitter for a whole packet, from its first byte to the byte flagged `last`. Bytes are paced by `tx_done` from the transceiver. A watchdog aborts a packet if either the requester or the transmitter stalls. The block sits between the requesters and `uart_transceiver.tx_data/tx_wr/tx_done`, in the same clock domain as the transceiver and `dds_uart_clock`.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 1000000: stall limit in `sys_clk` cycles, 2..2^24-1.

Ports:
- `sys_clk`, in, 1: system clock. All logic is on its rising edge.
- `sys_rst`, in, 1: reset, asynchronous, active-high.
- `req_valid`, in, NREQ: requester i has a byte on its lane.
- `req_data`, in, 8*NREQ: byte lane for requester i is `[8i+7:8i]`.
- `req_last`, in, NREQ: byte on lane i ends its packet.
- `req_ready`, out, NREQ: one-cycle pulse meaning lane i's byte was accepted.
- `grant`, out, NREQ: one-hot owner of the transmitter, or all zeros.
- `tx_data`, out, 8: to `uart_transceiver.tx_data`.
- `tx_wr`, out, 1: one-cycle write strobe to the transceiver.
- `tx_done`, in, 1: byte-complete pulse from the transceiver.
- `busy`, out, 1: high whenever the state is not IDLE.
- `timeout`, out, 1: one-cycle pulse when a packet is aborted.

## Operation
- All outputs are registered.
- Reset values: every output is 0, state is IDLE, `ptr` = NREQ-1 so requester 0 has first priority, and the stall counter is 0.
- States are IDLE, SEND and WAIT.
- **IDLE**
  - If any `req_valid` is high, grant the first set bit searching from `ptr+1` upward with wrap-around.
  - Set `grant` to that one-hot value, set `ptr` to its index, clear the stall counter, and go to SEND.
  - `tx_done` is ignored in IDLE.
- **SEND** (granted index g)
  - If `req_valid[g]`=1:
    - Register `tx_data <= req_data[g]` and `last_r <= req_last[g]`.
    - Next cycle, `tx_wr` and `req_ready[g]` are both 1.
    - Clear the stall counter and go to WAIT.
  - Else the state stays SEND and the stall counter increments.
  - `tx_done` is ignored in SEND.
- **WAIT**
  - On `tx_done`=1 with `last_r`=1: go to IDLE and clear `grant`.
  - On `tx_done`=1 with `last_r`=0: clear the stall counter and go to SEND. `grant` is unchanged.
  - Otherwise the stall counter increments.
  - `tx_done` is ignored in the first WAIT cycle, the one where `tx_wr`=1.
- **Abort**
  - In SEND or WAIT, when the stall counter equals TIMEOUT-1, pulse `timeout` for 1 cycle, clear `grant`, and go to IDLE.
  - `ptr` keeps the aborted index, so the aborted requester drops to lowest priority.
  - Any transceiver byte still in flight is not tracked.
- Other requesters' `req_valid` have no effect while a grant is held. There is no preemption.
- A requester dropping `req_valid` mid-packet only stalls the block; it does not end the packet.
- `req_last` is only sampled with an accepted byte.
- Stall counter width is ceil(log2(TIMEOUT)). It saturates by construction, because abort occurs first.
- `busy` = (state != IDLE), registered together with the state.
- **Asynchronous reset** at any time, including mid-packet:
  - All outputs and state return to reset values immediately.
  - No `req_ready` or `tx_wr` is generated for a byte that was pending.

## Timing
- Valid/ready handshake: a requester holds `req_data`/`req_last` stable while `req_valid`=1 until it sees `req_ready` high. It may change them in the cycle after that pulse.
- Latency from `req_valid` rising in IDLE (cycle 0):
  - `grant` at cycle 1.
  - `tx_wr` and `req_ready` at cycle 2.
- Byte-to-byte in a packet: `tx_done` at cycle n, then SEND at n+1, then the next `tx_wr` at n+2 if `req_valid` is already high.
- Packet-to-packet: `tx_done` of the last byte at cycle n, then IDLE at n+1, new `grant` at n+2, and `tx_wr` at n+3.
- `tx_wr` never occurs on two consecutive cycles. At most one `tx_wr` is outstanding per `tx_done`.

## Test plan
- **Reset values:** assert `sys_rst` with all `req_valid`=1, then release. Required: all outputs 0 during reset; `grant`=0001 one cycle after release; `tx_wr` one cycle later with `tx_data` = lane 0.
- **Two-byte packet:** requester 2 sends 0x41 then 0x42 (`last` set on 0x42); a transceiver model returns `tx_done` 20 cycles after each `tx_wr`. Required: exactly two `tx_wr` with 0x41 and 0x42, two `req_ready[2]` pulses, then `grant`=0 and `busy`=0.
- **Round-robin fairness:** requesters 0, 1 and 3 each hold valid single-byte packets continuously for 6 packets. Required: grant order 0,1,3,0,1,3. Requester 2 is never granted.
- **Packet atomicity:** requester 1 sends a 3-byte packet while requester 0 asserts valid from the first byte onward. Required: all 3 bytes of requester 1 are sent before `grant`=0001.
- **Requester stall:** with TIMEOUT=50, requester 3 sends one non-last byte then drops `req_valid`. Required: `timeout` pulses exactly 50 cycles after entering SEND; `grant` clears; next arbitration starts after requester 3.
- **Stray and mid-packet events:**
  - `tx_done` pulsed in IDLE and SEND: required to have no effect.
  - Async reset asserted in WAIT: required to clear outputs immediately with no further `tx_wr`.
